// File: rtl/tt_um_mikkelkofoed0708_adder_exerciser_pkg.sv
// Shared definitions for the adder exerciser: FSM state encoding, LFSR taps,
// default seed and the LFSR step function.
package tt_um_mikkelkofoed0708_adder_exerciser_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0].
    localparam logic [7:0] LfsrTaps    = 8'hB8;
    localparam logic [7:0] DefaultSeed = 8'hA5;

    // Shift left, feedback (XOR of tapped bits) enters at bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LfsrTaps)};
    endfunction

endpackage

// File: rtl/tt_um_mikkelkofoed0708_adder_exerciser_if.sv
// Pin bundle between the exerciser and the adder tile.
//   ui_in   : returned sum (into the exerciser)
//   uio_in  : unused input
//   uo_out  : operand A / error count
//   uio_out : operand B / first-fail index
//   uio_oe  : bidirectional output enables
// master = exerciser side, slave = adder side.
interface tt_um_mikkelkofoed0708_adder_exerciser_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

    modport slave (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );
endinterface

// File: rtl/adder_exerciser_lfsr.sv
// 8-bit Fibonacci LFSR supplying operand B.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : global enable; when low the register holds
//   load_i     : reload Seed
//   step_i     : advance one step
//   state_o    : current value
//   next_o     : value the register takes on the next enabled edge
module adder_exerciser_lfsr
    import tt_um_mikkelkofoed0708_adder_exerciser_pkg::*;
#(
    parameter logic [7:0] Seed = DefaultSeed
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] state_o,
    output logic [7:0] next_o
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = Seed;
        end else if (step_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= Seed;
        end else if (ena) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;
    // Only meaningful while ena is high; the top's output flops are gated the same way.
    assign next_o  = lfsr_d;

endmodule

// File: rtl/tt_um_mikkelkofoed0708_adder_exerciser.sv
// Self-running stimulus generator and checker for the 8-bit pin-level adder.
// Drives A=index and B=LFSR, samples the returned sum after a settle period,
// counts mismatches and records the first failing index. Runs once after
// reset, then parks in DONE showing error count / first-fail index.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : when low every register holds
//   pins       : pin bundle (master side)
module tt_um_mikkelkofoed0708_adder_exerciser
    import tt_um_mikkelkofoed0708_adder_exerciser_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_VECTORS   = 256,
    parameter logic [7:0]  LFSR_SEED     = DefaultSeed
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    tt_um_mikkelkofoed0708_adder_exerciser_if.master pins
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES);
    localparam logic [7:0] LastIdx    = 8'(NUM_VECTORS - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] err_q, err_d;
    logic [7:0] ff_q, ff_d;
    logic [7:0] uo_q, uo_d;
    logic [7:0] uio_q, uio_d;
    logic [7:0] oe_q, oe_d;

    logic       lfsr_load, lfsr_step_en;
    logic [7:0] lfsr_cur, lfsr_next;
    logic [7:0] expected_sum;

    logic unused_uio_in;
    assign unused_uio_in = ^pins.uio_in;

    adder_exerciser_lfsr #(
        .Seed (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step_en),
        .state_o (lfsr_cur),
        .next_o  (lfsr_next)
    );

    // Carry out of bit 7 is discarded.
    assign expected_sum = idx_q + lfsr_cur;

    // State register (all flops frozen while ena is low).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            uo_q    <= '0;
            uio_q   <= '0;
            oe_q    <= '0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            uo_q    <= uo_d;
            uio_q   <= uio_d;
            oe_q    <= oe_d;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        err_d        = err_q;
        ff_d         = ff_q;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d   = StRun;
                idx_d     = '0;
                cnt_d     = '0;
                lfsr_load = 1'b1;
            end
            StRun: begin
                if (cnt_q == SettleLast) begin
                    if (pins.ui_in != expected_sum) begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        if (err_q == 8'h00) begin
                            ff_d = idx_q;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d        = idx_q + 8'd1;
                        cnt_d        = '0;
                        lfsr_step_en = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next values, derived from next state so the pins are registered.
    always_comb begin
        uo_d  = 8'h00;
        uio_d = 8'h00;
        oe_d  = 8'h00;
        unique case (state_d)
            StIdle: begin
                oe_d = 8'h00;
            end
            StRun: begin
                uo_d  = idx_d;
                uio_d = lfsr_next;
                oe_d  = 8'hFF;
            end
            StDone: begin
                uo_d  = err_d;
                uio_d = (err_d != 8'h00) ? ff_d : 8'h00;
                oe_d  = 8'hFF;
            end
            default: begin
                oe_d = 8'h00;
            end
        endcase
    end

    assign pins.uo_out  = uo_q;
    assign pins.uio_out = uio_q;
    assign pins.uio_oe  = oe_q;

endmodule

// File: tb/tb_tt_um_mikkelkofoed0708_adder_exerciser.sv
module tb_tt_um_mikkelkofoed0708_adder_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ena;
    logic [7:0] uio_rand;
    logic [7:0] ui [2];
    logic [7:0] stage [2];
    int         mode;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Reference model state: enabled edges since reset, error count, first fail.
    logic [7:0]  tab [256];
    int unsigned ms [2] = '{2, 1};
    int unsigned mn [2] = '{256, 1};
    int unsigned mt [2];
    logic [7:0]  merr [2];
    logic [7:0]  mff [2];

    tt_um_mikkelkofoed0708_adder_exerciser_if bus0 ();
    tt_um_mikkelkofoed0708_adder_exerciser_if bus1 ();

    assign bus0.ui_in  = ui[0];
    assign bus1.ui_in  = ui[1];
    assign bus0.uio_in = uio_rand;
    assign bus1.uio_in = ~uio_rand;

    tt_um_mikkelkofoed0708_adder_exerciser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .pins  (bus0)
    );

    tt_um_mikkelkofoed0708_adder_exerciser #(
        .SETTLE_CYCLES (1),
        .NUM_VECTORS   (1),
        .LFSR_SEED     (8'hA5)
    ) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .pins  (bus1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pin_uo(input int k);
        return (k == 0) ? bus0.uo_out : bus1.uo_out;
    endfunction
    function automatic logic [7:0] pin_uio(input int k);
        return (k == 0) ? bus0.uio_out : bus1.uio_out;
    endfunction
    function automatic logic [7:0] pin_oe(input int k);
        return (k == 0) ? bus0.uio_oe : bus1.uio_oe;
    endfunction

    // Loopback adder with one cycle of delay plus optional corruption.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [7:0] sum;
            sum = pin_uo(k) + pin_uio(k);
            case (mode)
                1: if (pin_oe(k) == 8'hFF && pin_uo(k) == 8'h10) sum = sum ^ 8'h80;
                2: sum = ~sum;
                3: if ($urandom_range(0, 7) == 0) sum = sum ^ 8'($urandom_range(1, 255));
                default: ;
            endcase
            ui[k]    = stage[k];
            stage[k] = sum;
        end
        uio_rand = 8'($urandom);
    end

    // Behavioural model: a vector occupies S+1 enabled edges; the sum is judged
    // on the last edge of each vector from whatever the loopback presents.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mt[k] = 0; merr[k] = 8'h00; mff[k] = 8'h00;
            end
        end else if (ena === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                int unsigned per, v;
                per = ms[k] + 1;
                if (mt[k] >= per && mt[k] <= mn[k] * per && (mt[k] % per) == 0) begin
                    v = mt[k] / per - 1;
                    if (ui[k] != 8'(v + int'(tab[v]))) begin
                        if (merr[k] == 8'h00) mff[k] = 8'(v);
                        if (merr[k] != 8'hFF) merr[k] = merr[k] + 8'd1;
                    end
                end
                if (mt[k] < 100000) mt[k] = mt[k] + 1;
            end
        end
    end

    // Per-cycle compare of all pins of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [7:0] e_uo, e_uio, e_oe;
            int unsigned per;
            per = ms[k] + 1;
            if (mt[k] == 0) begin
                e_uo = 8'h00; e_uio = 8'h00; e_oe = 8'h00;
            end else if (mt[k] <= mn[k] * per) begin
                e_uo  = 8'((mt[k] - 1) / per);
                e_uio = tab[(mt[k] - 1) / per];
                e_oe  = 8'hFF;
            end else begin
                e_uo  = merr[k];
                e_uio = (merr[k] != 8'h00) ? mff[k] : 8'h00;
                e_oe  = 8'hFF;
            end
            chk($sformatf("model_uo_out[%0d]", k), 16'(pin_uo(k)), 16'(e_uo));
            chk($sformatf("model_uio_out[%0d]", k), 16'(pin_uio(k)), 16'(e_uio));
            chk($sformatf("model_uio_oe[%0d]", k), 16'(pin_oe(k)), 16'(e_oe));
        end
    end

    task automatic restart(input int m);
        @(negedge clk);
        #2 rst_n = 1'b0;
        mode = m;
        #1;
        chk("async_rst_oe", 16'(bus0.uio_oe), 16'h00);
        chk("async_rst_uo", 16'(bus0.uo_out), 16'h00);
        chk("async_rst_uio", 16'(bus0.uio_out), 16'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ena = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int i = 0;
        while (mt[0] < 769 && i < 6000) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_done_reached"}, 16'(mt[0] >= 769), 16'h1);
    endtask

    task automatic wait_index(input logic [7:0] idx);
        int i = 0;
        while (!(bus0.uio_oe == 8'hFF && bus0.uo_out == idx) && i < 2000) begin
            @(negedge clk);
            i++;
        end
        chk("wait_index", 16'(bus0.uo_out), 16'(idx));
    endtask

    initial begin
        logic [7:0] h_uo, h_uio, h_oe;
        tab[0] = 8'hA5;
        for (int i = 1; i < 256; i++) begin
            tab[i] = {tab[i-1][6:0], tab[i-1][7] ^ tab[i-1][5] ^ tab[i-1][4] ^ tab[i-1][3]};
        end
        for (int k = 0; k < 2; k++) begin
            mt[k] = 0; merr[k] = 8'h00; mff[k] = 8'h00; ui[k] = 8'h00; stage[k] = 8'h00;
        end
        mode = 0; rst_n = 1'b0; ena = 1'b0; uio_rand = 8'h00;

        chk("model_b1", 16'(tab[1]), 16'h4A);
        chk("model_b2", 16'(tab[2]), 16'h95);

        // Reset state and first vectors.
        repeat (3) @(negedge clk);
        chk("reset_uo", 16'(bus0.uo_out), 16'h00);
        chk("reset_uio", 16'(bus0.uio_out), 16'h00);
        chk("reset_oe", 16'(bus0.uio_oe), 16'h00);
        #2 rst_n = 1'b1; ena = 1'b1;
        @(negedge clk);
        chk("vec0_a", 16'(bus0.uo_out), 16'h00);
        chk("vec0_b", 16'(bus0.uio_out), 16'hA5);
        chk("vec0_oe", 16'(bus0.uio_oe), 16'hFF);
        chk("corner_vec0_b", 16'(bus1.uio_out), 16'hA5);
        @(negedge clk);
        chk("corner_hold_b", 16'(bus1.uio_out), 16'hA5);
        @(negedge clk);
        chk("corner_done_uo", 16'(bus1.uo_out), 16'h00);
        chk("corner_done_uio", 16'(bus1.uio_out), 16'h00);
        chk("corner_done_oe", 16'(bus1.uio_oe), 16'hFF);
        chk("vec0_still_b", 16'(bus0.uio_out), 16'hA5);
        @(negedge clk);
        chk("vec1_a", 16'(bus0.uo_out), 16'h01);
        chk("vec1_b", 16'(bus0.uio_out), 16'h4A);
        wait_done("clean");
        chk("clean_uo", 16'(bus0.uo_out), 16'h00);
        chk("clean_uio", 16'(bus0.uio_out), 16'h00);
        chk("clean_oe", 16'(bus0.uio_oe), 16'hFF);

        // Single fault at index 0x10.
        restart(1);
        wait_done("fault");
        chk("fault_uo", 16'(bus0.uo_out), 16'h01);
        chk("fault_uio", 16'(bus0.uio_out), 16'h10);

        // Always wrong: count saturates, first fail is index 0.
        restart(2);
        wait_done("wrong");
        chk("wrong_uo", 16'(bus0.uo_out), 16'hFF);
        chk("wrong_uio", 16'(bus0.uio_out), 16'h00);

        // ena stall at index 50.
        restart(0);
        wait_index(8'd50);
        #2 ena = 1'b0;
        h_uo = bus0.uo_out; h_uio = bus0.uio_out; h_oe = bus0.uio_oe;
        repeat (10) begin
            @(negedge clk);
            chk("stall_uo", 16'(bus0.uo_out), 16'(h_uo));
            chk("stall_uio", 16'(bus0.uio_out), 16'(h_uio));
            chk("stall_oe", 16'(bus0.uio_oe), 16'(h_oe));
        end
        #2 ena = 1'b1;
        wait_done("stall");
        chk("stall_final_uo", 16'(bus0.uo_out), 16'h00);
        chk("stall_final_uio", 16'(bus0.uio_out), 16'h00);

        // Reset mid-run at index 100, then a full clean restart.
        restart(0);
        wait_index(8'd100);
        restart(0);
        @(negedge clk);
        chk("rerun_vec0_a", 16'(bus0.uo_out), 16'h00);
        chk("rerun_vec0_b", 16'(bus0.uio_out), 16'hA5);
        wait_done("rerun");
        chk("rerun_uo", 16'(bus0.uo_out), 16'h00);
        chk("rerun_oe", 16'(bus0.uio_oe), 16'hFF);

        // Random corruption with random ena gaps; model judges every cycle.
        restart(3);
        begin
            int i = 0;
            while (mt[0] < 769 && i < 6000) begin
                @(negedge clk);
                #2 ena = ($urandom_range(0, 3) != 0);
                i++;
            end
            ena = 1'b1;
        end
        wait_done("random");
        repeat (3) @(negedge clk);
        chk("random_oe", 16'(bus0.uio_oe), 16'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
